// File: rtl/mem_access_unit.sv
// Load/store access unit sitting between the multicycle control FSM and data memory.
// Define MISALIGN_TRAP_EN to trap misaligned halfword/word accesses (fault=1, no memory access).
module mem_access_unit #(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wren,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        fault
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    localparam logic [1:0] WAIT_INIT = 2'(MEM_LATENCY - 1);

    state_t      state, state_next;
    logic [1:0]  cnt;
    logic        is_store_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    size_t       size_q;
    logic [3:0]  be;
    logic [31:0] wdata_rep;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_ext;
    logic        trap_in;

    // Undefined funct3 encodings fall through to word accesses.
    function automatic size_t decode_size(input logic [2:0] f);
        case (f)
            3'b000, 3'b100: return SZ_B;
            3'b001, 3'b101: return SZ_H;
            default:        return SZ_W;
        endcase
    endfunction

    assign size_q = decode_size(funct3_q);

`ifdef MISALIGN_TRAP_EN
    logic fault_q;
    always_comb begin
        trap_in = 1'b0;
        case (decode_size(funct3))
            SZ_H:    trap_in = addr[0];
            SZ_W:    trap_in = (addr[1:0] != 2'b00);
            default: trap_in = 1'b0;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst)
            fault_q <= 1'b0;
        else if (state == IDLE && start)
            fault_q <= trap_in;
    end
    assign fault = (state == DONE) && fault_q;
`else
    assign trap_in = 1'b0;
    assign fault   = 1'b0;
`endif

    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata_q;
        case (size_q)
            SZ_B: begin
                be        = 4'b0001 << addr_q[1:0];
                wdata_rep = {4{wdata_q[7:0]}};
            end
            SZ_H: begin
                be        = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    assign lane_b = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign lane_h = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        load_ext = mem_rdata;
        case (size_q)
            SZ_B:    load_ext = {{24{lane_b[7] & ~funct3_q[2]}}, lane_b};
            SZ_H:    load_ext = {{16{lane_h[15] & ~funct3_q[2]}}, lane_h};
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wren   = 1'b0;
        mem_be     = '0;
        case (state)
            IDLE: begin
                if (start)
                    state_next = trap_in ? DONE : ACCESS;
            end
            ACCESS: begin
                mem_addr   = {addr_q[31:2], 2'b00};
                mem_be     = be;
                mem_wdata  = wdata_rep;
                mem_wren   = is_store_q;
                state_next = is_store_q ? DONE : WAIT;
            end
            WAIT: begin
                mem_addr = {addr_q[31:2], 2'b00};
                mem_be   = be;
                if (cnt == 2'd0)
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            rdata      <= '0;
            is_store_q <= 1'b0;
            funct3_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && start) begin
                is_store_q <= is_store;
                funct3_q   <= funct3;
                addr_q     <= addr;
                wdata_q    <= wdata;
            end
            // Counter is loaded on leaving ACCESS so WAIT lasts exactly MEM_LATENCY cycles.
            if (state == ACCESS)
                cnt <= WAIT_INIT;
            else if (state == WAIT && cnt != 2'd0)
                cnt <= cnt - 2'd1;
            if (state == WAIT && cnt == 2'd0)
                rdata <= load_ext;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, randomized accesses
// against an arithmetic reference model, and a reset-during-WAIT sequence.
module tb_mem_access_unit;
    localparam int unsigned LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wren;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        fault;

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
        .addr(addr), .wdata(wdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wren(mem_wren), .mem_be(mem_be), .mem_rdata(mem_rdata), .rdata(rdata),
        .busy(busy), .done(done), .fault(fault)
    );

    // Memory returns real data only LAT cycles after a read address first appears.
    logic [31:0] mem [64];
    int unsigned age = 0;
    always @(posedge clk) age <= (mem_be != 4'b0000 && !mem_wren) ? age + 1 : 0;
    assign mem_rdata = (age == LAT) ? mem[mem_addr[7:2]] : 32'hBAD0_BAD0;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_rdata = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic void model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd,
                                  input logic [31:0] mw, output logic [3:0] be,
                                  output logic [31:0] wout, output logic [31:0] rout);
        int unsigned size, off;
        longint v;
        size = (f == 3'd0 || f == 3'd4) ? 1 : (f == 3'd1 || f == 3'd5) ? 2 : 4;
        off  = (a % 4) / size * size;
        be   = 4'(((1 << size) - 1) << off);
        wout = (size == 4) ? wd : (size == 2) ? (wd % 65536) * 32'h0001_0001
                                              : (wd % 256) * 32'h0101_0101;
        v = longint'((64'(mw) >> (8 * off)) % (64'd1 << (8 * size)));
        if (f < 3'd4 && size < 4 && v >= longint'(64'd1 << (8 * size - 1)))
            v = v - longint'(64'd1 << (8 * size));
        rout = 32'(v);
    endfunction

    // Starts in an IDLE cycle; returns in the IDLE cycle after DONE.
    task automatic txn(input string nm, input logic st, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] ebe, input logic [31:0] ew,
                       input logic [31:0] er);
        int cyc;
        chk({nm, " idle"}, 32'(busy), 32'd0);
        start = 1'b1; is_store = st; funct3 = f; addr = a; wdata = wd;
        @(posedge clk); #1;
        start = 1'b1; is_store = ~st; funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
        chk({nm, " acc addr"}, mem_addr, {a[31:2], 2'b00});
        chk({nm, " acc be"}, 32'(mem_be), 32'(ebe));
        chk({nm, " acc wren"}, 32'(mem_wren), 32'(st));
        if (st) chk({nm, " acc wdata"}, mem_wdata, ew);
        chk({nm, " acc busy/done"}, {30'd0, busy, done}, 32'd2);
        cyc = 1;
        while (!done && cyc < 12) begin
            @(posedge clk); #1;
            cyc++;
            start = 1'($urandom); addr = $urandom;
            if (!done) begin
                chk({nm, " wait addr"}, mem_addr, {a[31:2], 2'b00});
                chk({nm, " wait be/wren"}, {27'd0, mem_be, mem_wren}, {27'd0, ebe, 1'b0});
            end
        end
        if (!st) exp_rdata = er;
        chk({nm, " latency"}, 32'(cyc), st ? 32'd2 : 32'(2 + LAT));
        chk({nm, " done"}, 32'(done), 32'd1);
        chk({nm, " fault"}, 32'(fault), 32'd0);
        chk({nm, " done be/wren"}, {27'd0, mem_be, mem_wren}, 32'd0);
        chk({nm, " rdata"}, rdata, exp_rdata);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({nm, " post busy/done"}, {30'd0, busy, done}, 32'd0);
    endtask

    typedef struct {
        string       nm;
        logic        st;
        logic [2:0]  f;
        logic [31:0] a, wd, mw;
        logic [3:0]  be;
        logic [31:0] ew, er;
    } vec_t;

    vec_t vecs[13];

    initial begin
        logic [3:0]  rbe;
        logic [31:0] rw, rr, ra, rwd;
        logic [2:0]  rf;
        logic        rst_st;
        int          seen;

        vecs[0]  = '{"sw",      1'b1, 3'd2, 32'h104, 32'hDEADBEEF, 32'h0,        4'hF, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{"sb",      1'b1, 3'd0, 32'h103, 32'h000000A5, 32'h0,        4'h8, 32'hA5A5A5A5, 32'h0};
        vecs[2]  = '{"lb",      1'b0, 3'd0, 32'h202, 32'h0,        32'h12F03456, 4'h4, 32'h0,        32'hFFFFFFF0};
        vecs[3]  = '{"lbu",     1'b0, 3'd4, 32'h202, 32'h0,        32'h12F03456, 4'h4, 32'h0,        32'h000000F0};
        vecs[4]  = '{"lh",      1'b0, 3'd1, 32'h202, 32'h0,        32'h80017777, 4'hC, 32'h0,        32'hFFFF8001};
        vecs[5]  = '{"lhu",     1'b0, 3'd5, 32'h200, 32'h0,        32'h80017777, 4'h3, 32'h0,        32'h00007777};
        vecs[6]  = '{"lw mis",  1'b0, 3'd2, 32'h301, 32'h0,        32'hCAFEF00D, 4'hF, 32'h0,        32'hCAFEF00D};
        vecs[7]  = '{"sh",      1'b1, 3'd1, 32'h102, 32'h1234ABCD, 32'h0,        4'hC, 32'hABCDABCD, 32'h0};
        vecs[8]  = '{"sh mis",  1'b1, 3'd1, 32'h101, 32'h00005AA5, 32'h0,        4'h3, 32'h5AA55AA5, 32'h0};
        vecs[9]  = '{"ld f011", 1'b0, 3'd3, 32'h010, 32'h0,        32'h89ABCDEF, 4'hF, 32'h0,        32'h89ABCDEF};
        vecs[10] = '{"lb pos",  1'b0, 3'd0, 32'h201, 32'h0,        32'h00007F00, 4'h2, 32'h0,        32'h0000007F};
        vecs[11] = '{"st f110", 1'b1, 3'd6, 32'h1F3, 32'h01234567, 32'h0,        4'hF, 32'h01234567, 32'h0};
        vecs[12] = '{"lh mis",  1'b0, 3'd1, 32'h203, 32'h0,        32'h80017777, 4'hC, 32'h0,        32'hFFFF8001};

        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = '0; addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset outputs", {mem_addr ^ mem_wdata, 28'd0}, 32'd0);
        chk("reset ctrl", {25'd0, mem_wren, mem_be, busy, done, fault}, 32'd0);
        chk("reset rdata", rdata, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            if (!vecs[i].st) mem[vecs[i].a[7:2]] = vecs[i].mw;
            txn(vecs[i].nm, vecs[i].st, vecs[i].f, vecs[i].a, vecs[i].wd,
                vecs[i].be, vecs[i].ew, vecs[i].er);
        end

        for (int i = 0; i < 40; i++) begin
            rst_st = 1'($urandom);
            rf  = 3'($urandom);
            ra  = $urandom;
            rwd = $urandom;
            model(rf, ra, rwd, mem[ra[7:2]], rbe, rw, rr);
            txn("rand", rst_st, rf, ra, rwd, rbe, rw, rr);
        end

        // Reset during WAIT of a word load aborts it without a done pulse.
        mem[0] = 32'h13572468;
        start = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h300;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_rdata = '0;
        chk("rst mid busy/done", {30'd0, busy, done}, 32'd0);
        chk("rst mid mem", {27'd0, mem_wren, mem_be}, 32'd0);
        chk("rst mid addr", mem_addr, 32'd0);
        chk("rst mid rdata", rdata, 32'd0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        chk("rst no done", 32'(seen), 32'd0);
        txn("after rst", 1'b0, 3'd2, 32'h300, 32'h0, 4'hF, 32'h0, 32'h13572468);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter MEM_LATENCY, default 1, meaning data-memory read latency in cycles, legal range 1..4.
REQ-002 clk  input  1  system clock; all state changes on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  access request from the multicycle control unit's MEMORY state; sampled only in IDLE.
REQ-005 is_store  input  1  1 = store, 0 = load; sampled with start.
REQ-006 funct3  input  3  access size/sign (000 b, 001 h, 010 w, 100 bu, 101 hu); sampled with start.
REQ-007 addr  input  32  byte address (ALU result); sampled with start.
REQ-008 wdata  input  32  store data (rs2); sampled with start.
REQ-009 mem_addr  output  32  word-aligned memory address.
REQ-010 mem_wdata  output  32  lane-replicated store data.
REQ-011 mem_wren  output  1  memory write strobe.
REQ-012 mem_be  output  4  byte enables, bit i = byte lane i (little-endian).
REQ-013 mem_rdata  input  32  memory read data, valid MEM_LATENCY cycles after mem_addr is presented.
REQ-014 rdata  output  32  extended load result for writeback.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 fault  output  1  misaligned-access flag, valid while done=1.

Function
REQ-018 FSM states IDLE, ACCESS, WAIT, DONE; start, is_store, funct3, addr and wdata are registered on acceptance; start is ignored outside IDLE.
REQ-019 IDLE: start=1 -> ACCESS at next posedge; otherwise remain in IDLE.
REQ-020 ACCESS (exactly 1 cycle): drive mem_addr={addr[31:2],2'b00}, mem_be, mem_wdata; mem_wren=1 only for stores; store -> DONE; load -> WAIT.
REQ-021 WAIT: hold mem_addr/mem_be; stay MEM_LATENCY cycles using a 2-bit down-counter; capture extended mem_rdata into rdata on the posedge ending the last WAIT cycle -> DONE.
REQ-022 DONE (1 cycle): done=1 -> IDLE; a start in the following IDLE cycle is accepted normally (back-to-back throughput).
REQ-023 Latency start->done: store 2 cycles; load 2+MEM_LATENCY cycles.
REQ-024 Byte enables: b/bu -> 4'b0001<<addr[1:0]; h/hu -> addr[1] ? 4'b1100 : 4'b0011; w -> 4'b1111.
REQ-025 Store data: byte replicated x4 (wdata[7:0]); halfword replicated x2 (wdata[15:0]); word passed through.
REQ-026 Load extraction: byte lane addr[1:0], halfword lane addr[1]; b/h sign-extended, bu/hu zero-extended, w unchanged.
REQ-027 Undefined funct3 (011, 110, 111) treated as w.
REQ-028 rdata holds its value until the next completed load; stores do not modify rdata.
REQ-029 mem_wren, mem_be are 0 outside ACCESS/WAIT; mem_wren is never high for more than one cycle per store.

Reset
REQ-030 rst=1 at posedge forces IDLE, counter=0, rdata=0, mem_addr=0, mem_wdata=0, mem_wren=0, mem_be=0, busy=0, done=0, fault=0.
REQ-031 rst asserted mid-access aborts the access; no done pulse is produced for it and mem_wren is 0 from the next cycle.

Configuration
REQ-032 Macro MISALIGN_TRAP_EN defined: h/hu with addr[0]=1, or w with addr[1:0]!=0, goes IDLE -> DONE directly, with fault=1, mem_wren never asserted, rdata unchanged.
REQ-033 MISALIGN_TRAP_EN undefined: fault tied 0; misaligned low address bits ignored (h uses addr[1] only, w uses lane 0) and the access proceeds.

Verification
REQ-034 sw addr=0x104 wdata=0xDEADBEEF -> ACCESS cycle mem_addr=0x104, be=1111, wren=1 one cycle; done 2 cycles after start.
REQ-035 sb addr=0x103 wdata=0x000000A5 -> mem_wdata=0xA5A5A5A5, be=1000.
REQ-036 lb addr=0x202, mem_rdata=0x12F0_3456, MEM_LATENCY=1 -> rdata=0xFFFFFFF0, done 3 cycles after start; lbu same -> 0x000000F0.
REQ-037 lh addr=0x202, MEM_LATENCY=3, mem_rdata=0x8001_7777 -> rdata=0xFFFF8001, done 5 cycles after start.
REQ-038 lw addr=0x301: with MISALIGN_TRAP_EN -> done+fault=1 one cycle after start, no memory access; without -> reads 0x300, fault=0.
REQ-039 rst raised in WAIT of lw -> busy=0 next cycle, no done, rdata=0; new start afterwards completes normally.
